csel_adder_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-select adder/subtractor with a valid/ready handshake and multi-word carry chaining. It is the successor to the fixed 16-bit, 4-bit-block carry-select adder and serves as the datapath arithmetic unit wherever a streaming add/sub of configurable width is needed. A registered carry lets wider operands be processed as back-to-back chained words.

---
 rtl/csel_adder_pipe.sv | 133 +++++++++++++
 tb/tb_csel_adder_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_adder_pipe.sv
// rtl/csel_adder_pipe.sv - two-stage pipelined carry-select add/sub with valid/ready and carry chaining
// Stage 1 precomputes both block sums per carry-in; stage 2 resolves the carry-select chain.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic                   cin,
  input  logic                   sub,
  input  logic                   chain,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       S,
  output logic                   C,
  output logic                   V,
  output logic [WIDTH/BLOCK-2:0] innerCarry
);
  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum0;
  logic [WIDTH-1:0] w_sum1;
  logic [NBLK-1:0]  w_c0;
  logic [NBLK-1:0]  w_c1;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_s1_move;
  logic             w_ceff;
  logic [NBLK:0]    w_carry;
  logic [WIDTH-1:0] w_s;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_sum0;
  logic [WIDTH-1:0] r_sum1;
  logic [NBLK-1:0]  r_c0;
  logic [NBLK-1:0]  r_c1;
  logic             r_a_msb;
  logic             r_bx_msb;
  logic             r_cin;
  logic             r_sub;
  logic             r_chain;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;
  logic [NBLK-2:0]  r_inner;

  assign w_s1_adv  = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_s1_move = r_s1_valid && w_s1_adv;

  always_comb begin
    w_bx   = sub ? ~B : B;
    w_sum0 = '0;
    w_sum1 = '0;
    w_c0   = '0;
    w_c1   = '0;
    for (int k = 0; k < NBLK; k++) begin
      {w_c0[k], w_sum0[k*BLOCK +: BLOCK]} = {1'b0, A[k*BLOCK +: BLOCK]} + {1'b0, w_bx[k*BLOCK +: BLOCK]};
      {w_c1[k], w_sum1[k*BLOCK +: BLOCK]} = {1'b0, A[k*BLOCK +: BLOCK]} + {1'b0, w_bx[k*BLOCK +: BLOCK]}
                                            + (BLOCK+1)'(1);
    end
  end

  // The registered carry-out doubles as the chaining carry: it loads on every op entering the output.
  always_comb begin
    w_ceff     = r_chain ? r_c : (r_sub | r_cin);
    w_carry    = '0;
    w_s        = '0;
    w_carry[0] = w_ceff;
    for (int k = 0; k < NBLK; k++) begin
      w_s[k*BLOCK +: BLOCK] = w_carry[k] ? r_sum1[k*BLOCK +: BLOCK] : r_sum0[k*BLOCK +: BLOCK];
      w_carry[k+1]          = w_carry[k] ? r_c1[k] : r_c0[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_sum0      <= '0;
      r_sum1      <= '0;
      r_c0        <= '0;
      r_c1        <= '0;
      r_a_msb     <= 1'b0;
      r_bx_msb    <= 1'b0;
      r_cin       <= 1'b0;
      r_sub       <= 1'b0;
      r_chain     <= 1'b0;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_inner     <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_sum0     <= w_sum0;
        r_sum1     <= w_sum1;
        r_c0       <= w_c0;
        r_c1       <= w_c1;
        r_a_msb    <= A[WIDTH-1];
        r_bx_msb   <= w_bx[WIDTH-1];
        r_cin      <= cin;
        r_sub      <= sub;
        r_chain    <= chain;
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_move) begin
        r_out_valid <= 1'b1;
        r_s         <= w_s;
        r_c         <= w_carry[NBLK];
        r_v         <= (r_a_msb ~^ r_bx_msb) & (w_s[WIDTH-1] ^ r_a_msb);
        r_inner     <= w_carry[NBLK-1:1];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign S          = r_s;
  assign C          = r_c;
  assign V          = r_v;
  assign innerCarry = r_inner;
endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb/tb_csel_adder_pipe.sv - self-checking bench for csel_adder_pipe
// Table-driven directed vectors, hand-written pipeline sequences and a scoreboarded random stream.
module tb_csel_adder_pipe;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic cin; logic sub; logic chain;} op_t;
  typedef struct packed {logic [15:0] s; logic c; logic v; logic [2:0] ic;} res_t;
  typedef struct packed {op_t op; res_t exp;} vec_t;

  localparam int NV = 11;
  localparam int NR = 2000;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ci = 0;
  logic        sb = 0;
  logic        ch = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] s;
  logic        c;
  logic        v;
  logic [2:0]  ic;

  logic        iv32 = 0;
  logic        ir32;
  logic        ov32;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        sb32 = 0;
  logic [31:0] s32;
  logic        c32;
  logic        v32;
  logic [2:0]  ic32;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   abort = 0;
  res_t got[$];
  int   got_cyc[$];

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .cin(ci), .sub(sb), .chain(ch), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .C(c), .V(v), .innerCarry(ic)
  );

  csel_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .cin(1'b0), .sub(sb32), .chain(1'b0), .out_valid(ov32), .out_ready(1'b1),
    .S(s32), .C(c32), .V(v32), .innerCarry(ic32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got.push_back({s, c, v, ic});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish before 600000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic res_t model(input op_t o, input logic cr);
    res_t   r;
    logic [15:0] bx;
    logic   cie;
    longint m;
    longint lo;
    bx  = o.sub ? ~o.b : o.b;
    cie = o.chain ? cr : (o.sub ? 1'b1 : o.cin);
    lo  = longint'(o.a) + longint'(bx) + longint'(cie);
    r.s = lo[15:0];
    r.c = lo[16];
    r.v = (o.a[15] == bx[15]) && (lo[15] != o.a[15]);
    for (int k = 0; k < 3; k++) begin
      m  = (longint'(1) << (4*(k+1))) - 1;
      lo = (longint'(o.a) & m) + (longint'(bx) & m) + longint'(cie);
      r.ic[k] = lo[4*(k+1)];
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] va, vb, input logic vc, vs, vch,
                              input logic [15:0] es, input logic ec, ev, input logic [2:0] eic);
    vec_t t;
    t.op  = '{a: va, b: vb, cin: vc, sub: vs, chain: vch};
    t.exp = '{s: es, c: ec, v: ev, ic: eic};
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the op has been accepted.
  task automatic send(input op_t o, output int acc);
    int n;
    n   = 0;
    acc = 0;
    if (abort) return;
    a = o.a; b = o.b; ci = o.cin; sb = o.sub; ch = o.chain; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {31'b0, in_ready}, 32'd1);
    if (!in_ready) abort = 1;
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_res(output res_t r, output int vc, output bit ok);
    int n;
    n = 0;
    r = '0;
    vc = 0;
    while (got.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n > 0) #1;
    ok = (got.size() > 0);
    chk("result_arrives", {31'b0, ok}, 32'd1);
    if (ok) begin
      r  = got.pop_front();
      vc = got_cyc.pop_front();
    end else begin
      abort = 1;
    end
  endtask

  vec_t vecs [NV];
  op_t  bp   [4];
  op_t  sent[$];
  res_t r;
  res_t r2;
  res_t e;
  op_t  o;
  int   acc;
  int   acc2;
  int   vc;
  int   vc2;
  bit   ok;
  bit   done;
  logic mcr;

  initial begin
    vecs[0]  = mk(16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 3'b111);
    vecs[1]  = mk(16'h0005, 16'h0007, 0, 1, 0, 16'hFFFE, 0, 0, 3'b000);
    vecs[2]  = mk(16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1, 3'b000);
    vecs[3]  = mk(16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1, 3'b111);
    vecs[4]  = mk(16'h1234, 16'h4321, 1, 0, 0, 16'h5556, 0, 0, 3'b000);
    vecs[5]  = mk(16'h00F0, 16'h0010, 0, 0, 0, 16'h0100, 0, 0, 3'b010);
    vecs[6]  = mk(16'h0010, 16'h0010, 0, 1, 0, 16'h0000, 1, 0, 3'b111);
    vecs[7]  = mk(16'h0001, 16'h0000, 0, 0, 1, 16'h0002, 0, 0, 3'b000);
    vecs[8]  = mk(16'h0001, 16'h0000, 1, 0, 1, 16'h0001, 0, 0, 3'b000);
    vecs[9]  = mk(16'h8000, 16'h8000, 0, 0, 0, 16'h0000, 1, 1, 3'b000);
    vecs[10] = mk(16'h0003, 16'h0001, 0, 1, 1, 16'h0002, 1, 0, 3'b111);

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_S", {16'b0, s}, 32'd0);
    chk("rst_C_V_ic", {27'b0, c, v, ic}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, acc);
      wait_res(r, vc, ok);
      chk($sformatf("vec%0d_S", i), {16'b0, r.s}, {16'b0, vecs[i].exp.s});
      chk($sformatf("vec%0d_C", i), {31'b0, r.c}, {31'b0, vecs[i].exp.c});
      chk($sformatf("vec%0d_V", i), {31'b0, r.v}, {31'b0, vecs[i].exp.v});
      chk($sformatf("vec%0d_innerCarry", i), {29'b0, r.ic}, {29'b0, vecs[i].exp.ic});
      chk($sformatf("vec%0d_latency", i), 32'(vc - acc), 32'd2);
    end

    // 32-bit value as two chained 16-bit beats, issued back to back.
    send('{a: 16'hFFFF, b: 16'h0001, cin: 0, sub: 0, chain: 0}, acc);
    send('{a: 16'h0001, b: 16'h0000, cin: 0, sub: 0, chain: 1}, acc2);
    wait_res(r, vc, ok);
    wait_res(r2, vc2, ok);
    chk("chain_lo_S_C", {15'b0, r.s, r.c}, {15'b0, 16'h0000, 1'b1});
    chk("chain_hi_S_C", {15'b0, r2.s, r2.c}, {15'b0, 16'h0002, 1'b0});
    chk("chain_b2b_accept", 32'(acc2 - acc), 32'd1);
    chk("chain_b2b_result", 32'(vc2 - vc), 32'd1);

    bp[0] = '{a: 16'h1111, b: 16'h2222, cin: 0, sub: 0, chain: 0};
    bp[1] = '{a: 16'hF000, b: 16'h1000, cin: 0, sub: 0, chain: 0};
    bp[2] = '{a: 16'h0100, b: 16'h0001, cin: 0, sub: 1, chain: 0};
    bp[3] = '{a: 16'h7FFF, b: 16'h7FFF, cin: 1, sub: 0, chain: 0};
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i], acc);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_S_1", {16'b0, s}, {16'b0, model(bp[0], 1'b0).s});
        @(negedge clk);
        chk("bp_hold_S_2", {16'b0, s}, {16'b0, model(bp[0], 1'b0).s});
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    for (int i = 0; i < 4; i++) begin
      wait_res(r, vc, ok);
      chk($sformatf("bp_order%0d", i), 32'(r), 32'(model(bp[i], 1'b0)));
    end

    // Two ops in flight, both leaving carry=1, then reset.
    out_ready = 0;
    send('{a: 16'hFFFF, b: 16'h0001, cin: 0, sub: 0, chain: 0}, acc);
    send('{a: 16'hFFFF, b: 16'h0001, cin: 0, sub: 0, chain: 0}, acc);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(got.size()), 32'd0);
    send('{a: 16'h0001, b: 16'h0001, cin: 0, sub: 0, chain: 1}, acc);
    wait_res(r, vc, ok);
    chk("midrst_chain_S_C", {15'b0, r.s, r.c}, {15'b0, 16'h0002, 1'b0});

    mcr  = 1'b0;
    done = 0;
    fork
      begin
        for (int i = 0; i < NR && !abort; i++) begin
          o.a     = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          o.b     = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
          o.cin   = 1'($urandom);
          o.sub   = 1'($urandom);
          o.chain = ($urandom_range(2) == 0);
          sent.push_back(o);
          send(o, acc);
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        for (int i = 0; i < NR && !abort; i++) begin
          wait_res(r, vc, ok);
          if (!ok) break;
          if (sent.size() > 0) begin
            e   = model(sent.pop_front(), mcr);
            mcr = e.c;
            chk($sformatf("rand%0d", i), 32'(r), 32'(e));
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rand_no_extra", 32'(got.size()), 32'd0);

    for (int i = 0; i < 2; i++) begin
      int n;
      a32  = (i == 0) ? 32'h7FFFFFFF : 32'h00000000;
      b32  = 32'h00000001;
      sb32 = (i == 1);
      iv32 = 1;
      @(negedge clk);
      chk($sformatf("w32_%0d_in_ready", i), {31'b0, ir32}, 32'd1);
      @(posedge clk);
      #1;
      iv32 = 0;
      n = 0;
      @(negedge clk);
      while (!ov32 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("w32_%0d_valid", i), {31'b0, ov32}, 32'd1);
      chk($sformatf("w32_%0d_S", i), s32, (i == 0) ? 32'h80000000 : 32'hFFFFFFFF);
      chk($sformatf("w32_%0d_C_V_ic", i), {27'b0, c32, v32, ic32},
          (i == 0) ? {27'b0, 1'b0, 1'b1, 3'b111} : 32'd0);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
